button_debouncer: RTL and testbench
===================================

# button_debouncer

Synchronises and debounces one raw, active-high push-button input (e.g. BtnC) into a clean level plus single-cycle edge pulses. It sits directly upstream of the LED blinker: `btn_level` drives the blinker's active-high reset, and `btn_rise`/`btn_fall` are available to mode/toggle logic. It runs in the 200 MHz domain produced by the differential clock buffer.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles the synchronised input must stay stable before a change is accepted (10 ms at 200 MHz). Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 200_000_000: cycles in the debounced-high state before `btn_long` fires (1 s). Must be ≥ 2.
- `clk_200mhz`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_raw`, input, 1: raw button pin; asynchronous, bouncy, active-high.
- `btn_level`, output, 1: debounced button level.
- `btn_rise`, output, 1: one-cycle pulse when `btn_level` goes 0→1.
- `btn_fall`, output, 1: one-cycle pulse when `btn_level` goes 1→0.
- `btn_long`, output, 1: one-cycle long-press pulse (see Configuration).

## Operation
- **Synchroniser:** two-flop chain `btn_raw` → s1 → s2. Both flops reset to 0. Only s2 is used downstream.
- **Debounce counter:** `$clog2(DEBOUNCE_CYCLES)` bits, unsigned, reset to 0. It never wraps; it is cleared on every state change.
- **FSM states and transitions:**
  - IDLE_LOW (reset state): s2=1 → WAIT_HIGH, counter cleared.
  - WAIT_HIGH, s2=0 → IDLE_LOW (bounce rejected, no output change).
  - WAIT_HIGH, s2=1 and counter==DEBOUNCE_CYCLES-1 → IDLE_HIGH. Set `btn_level`=1 and pulse `btn_rise`.
  - WAIT_HIGH, otherwise: counter increments.
  - IDLE_HIGH: s2=0 → WAIT_LOW, counter cleared.
  - WAIT_LOW: mirrors WAIT_HIGH with polarity inverted. On acceptance, go to IDLE_LOW, set `btn_level`=0 and pulse `btn_fall`.
- **Output registers:** all outputs are registered. The pulses are high for exactly one cycle. `btn_rise` and `btn_fall` are never high in the same cycle.
- **Reset values:** `btn_level`, `btn_rise`, `btn_fall` and `btn_long` are all 0. The FSM is in IDLE_LOW and all counters are 0.
- **Reset mid-operation:** asserting `reset_n` low at any time immediately forces the reset values, including during WAIT_* states and while a pulse is high.
- **Pre-pressed input:** if the button is already pressed when `reset_n` deasserts, it is treated as a fresh press. The normal rise latency applies.

## Timing
- Rise latency: with `btn_raw` stable high from edge 0, s2=1 after edge 2. The FSM enters WAIT_HIGH at edge 3 with counter=0. `btn_level` and `btn_rise` assert after edge DEBOUNCE_CYCLES+3.
- Fall latency: identical, DEBOUNCE_CYCLES+3 cycles.
- Bounce rejection: any return of s2 to the idle value during a WAIT_* state aborts acceptance. The full count restarts on the next change.
- The minimum accepted stable window is DEBOUNCE_CYCLES+1 consecutive s2 samples.
- No backpressure and no handshake: the outputs are free-running.

## Configuration
- Macro: `BUTTON_DEBOUNCER_LONG_PRESS_EN`.
- **Defined:** a long-press counter of `$clog2(LONG_PRESS_CYCLES)` bits is built.
  - It is 0 on entry to IDLE_HIGH and increments each cycle in IDLE_HIGH and WAIT_LOW (a bounce does not restart it).
  - When it reaches LONG_PRESS_CYCLES-1, `btn_long` pulses for one cycle. The counter then saturates, so there is one pulse per press.
  - It is cleared when the FSM enters IDLE_LOW.
- **Undefined:** no long-press counter is synthesised, and `btn_long` is tied to constant 0. The port list is unchanged.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, `BUTTON_DEBOUNCER_LONG_PRESS_EN` defined unless stated.
- Hold `reset_n`=0 with `btn_raw`=1 → all outputs 0. Release reset at edge 0 → `btn_level`=1 and `btn_rise`=1 after edge 11; `btn_rise`=0 after edge 12.
- Raise `btn_raw` at edge 0, hold 100 cycles, then lower it → `btn_fall` is a single 1-cycle pulse 11 cycles after the fall, and `btn_level` returns to 0 at the same edge.
- Toggle `btn_raw` high 5 cycles / low 3 cycles, repeated 10 times → `btn_level`, `btn_rise` and `btn_fall` stay 0 throughout.
- Hold `btn_raw` high from edge 0 → `btn_level` rises after edge 11; `btn_long` pulses once after edge 43 and does not repeat by edge 200. With the macro undefined, `btn_long` stays 0.
- Hold `btn_raw` high for 6 cycles, pulse `reset_n` low for 1 cycle, keep `btn_raw` high → outputs are 0 during reset; `btn_level` rises 11 cycles after reset deassertion.
- During a 50-cycle press, inject a 4-cycle low glitch → no `btn_fall`, `btn_level` stays 1, and `btn_long` still fires 32 cycles after the original rise.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, registered level and edge pulses.
// Optional long-press detector on btn_long, built when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic clk_200mhz,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

  logic            sync1_reg;
  logic            sync2_reg;
  state_t          state_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;
  logic            rise_reg;
  logic            fall_reg;

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
      $error("button_debouncer: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must both be at least 2");
    end
  endgenerate

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Any disagreement of sync2 with the pending level aborts the wait and the count restarts.
  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE_LOW;
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        IDLE_LOW: begin
          if (sync2_reg) begin
            state_reg  <= WAIT_HIGH;
            db_cnt_reg <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_reg) begin
            state_reg  <= IDLE_LOW;
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg  <= IDLE_HIGH;
            db_cnt_reg <= '0;
            level_reg  <= 1'b1;
            rise_reg   <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!sync2_reg) begin
            state_reg  <= WAIT_LOW;
            db_cnt_reg <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2_reg) begin
            state_reg  <= IDLE_HIGH;
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg  <= IDLE_LOW;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            fall_reg   <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
        default: begin
          state_reg  <= IDLE_LOW;
          db_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign btn_level = level_reg;
  assign btn_rise  = rise_reg;
  assign btn_fall  = fall_reg;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int              LP_W    = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_reg;
  logic            lp_done_reg;
  logic            long_reg;

  // Counts through IDLE_HIGH and WAIT_LOW so a release bounce does not restart the hold time;
  // held at zero in IDLE_LOW/WAIT_HIGH, which also makes it 0 on entry to IDLE_HIGH.
  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      lp_cnt_reg  <= '0;
      lp_done_reg <= 1'b0;
      long_reg    <= 1'b0;
    end else begin
      long_reg <= 1'b0;
      if (state_reg == IDLE_HIGH || state_reg == WAIT_LOW) begin
        if (lp_cnt_reg == LP_LAST) begin
          if (!lp_done_reg) begin
            long_reg    <= 1'b1;
            lp_done_reg <= 1'b1;
          end
        end else begin
          lp_cnt_reg <= lp_cnt_reg + LP_W'(1);
        end
      end else begin
        lp_cnt_reg  <= '0;
        lp_done_reg <= 1'b0;
      end
    end
  end

  assign btn_long = long_reg;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed button waveforms push expected pulse events into a queue;
// a negedge monitor pops them at their due cycle and compares every output each cycle.
module tb_button_debouncer;

  localparam int DB     = 8;
  localparam int LP     = 32;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  logic clk_200mhz = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_long;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic lvl_exp = 1'b0;

  typedef struct {
    int    kind;
    int    at;
    string name;
  } ev_t;

  ev_t exp_q[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk_200mhz(clk_200mhz),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_long  (btn_long)
  );

  always #5 clk_200mhz = ~clk_200mhz;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk_200mhz) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic push(input int kind, input int at, input string name);
    ev_t ev;
    ev.kind = kind;
    ev.at   = at;
    ev.name = name;
    exp_q.push_back(ev);
  endtask

  task automatic push_long(input int at);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    push(K_LONG, at, "long");
`else
    if (at < 0) push(K_LONG, at, "long");
`endif
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_200mhz);
    #1;
  endtask

  // Monitor: outputs are free-running, so every cycle is a presentation point.
  always @(negedge clk_200mhz) begin
    logic er;
    logic ef;
    logic el;
    ev_t  ev;
    er = 1'b0;
    ef = 1'b0;
    el = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      ev = exp_q.pop_front();
      if (ev.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_overdue: due at cycle %0d, still queued at cycle %0d", ev.name, ev.at, cyc);
      end else begin
        $display("event %-4s due at cycle %0d: level=%0b rise=%0b fall=%0b long=%0b",
                 ev.name, ev.at, btn_level, btn_rise, btn_fall, btn_long);
        case (ev.kind)
          K_RISE:  er = 1'b1;
          K_FALL:  ef = 1'b1;
          default: el = 1'b1;
        endcase
      end
    end
    if (!reset_n) lvl_exp = 1'b0;
    else if (er)  lvl_exp = 1'b1;
    else if (ef)  lvl_exp = 1'b0;
    check_bit("btn_level", btn_level, lvl_exp);
    check_bit("btn_rise",  btn_rise,  er);
    check_bit("btn_fall",  btn_fall,  ef);
    check_bit("btn_long",  btn_long,  el);
  end

  initial begin
    int t0;
    reset_n = 1'b0;
    btn_raw = 1'b1;

    // Reset held with the button already pressed: everything stays 0.
    step(5);
    check_bit("reset_level", btn_level, 1'b0);
    check_bit("reset_rise",  btn_rise,  1'b0);
    check_bit("reset_fall",  btn_fall,  1'b0);
    check_bit("reset_long",  btn_long,  1'b0);

    // Pre-pressed input at reset release is a fresh press.
    reset_n = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    push_long(t0 + 43);
    step(60);
    btn_raw = 1'b0;
    push(K_FALL, cyc + 11, "fall");
    step(30);

    // 100-cycle press then release.
    btn_raw = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    push_long(t0 + 43);
    step(100);
    btn_raw = 1'b0;
    push(K_FALL, cyc + 11, "fall");
    step(30);

    // Bounce: 5 high / 3 low never reaches the stable window.
    for (int i = 0; i < 10; i++) begin
      btn_raw = 1'b1;
      step(5);
      btn_raw = 1'b0;
      step(3);
    end
    step(20);

    // Long hold: one long pulse only, none repeated up to edge 200.
    btn_raw = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    push_long(t0 + 43);
    step(200);
    btn_raw = 1'b0;
    push(K_FALL, cyc + 11, "fall");
    step(30);

    // Reset pulse mid-debounce, then reset while level is high, then a short press.
    btn_raw = 1'b1;
    step(6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    push_long(t0 + 43);
    step(50);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    step(20);
    btn_raw = 1'b0;
    push(K_FALL, cyc + 11, "fall");
    step(30);

    // 50-cycle press with a 4-cycle release glitch: no fall, long timing unaffected.
    btn_raw = 1'b1;
    t0 = cyc;
    push(K_RISE, t0 + 11, "rise");
    push_long(t0 + 43);
    step(20);
    btn_raw = 1'b0;
    step(4);
    btn_raw = 1'b1;
    step(26);
    btn_raw = 1'b0;
    push(K_FALL, cyc + 11, "fall");
    step(30);

    check_int("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
